// File: rtl/inv_key_schedule_if.sv
// Stream/control bundle between the key register, the decryption key scheduler
// and the inverse-cipher round datapath.
interface inv_key_schedule_if;
  logic         start;
  logic         lastKey;
  logic [127:0] keyIn;
  logic         keyReady;
  logic [127:0] keyOut;
  logic [3:0]   keyRound;
  logic         keyValid;
  logic         busy;
  logic         done;

  modport master (
    output start, lastKey, keyIn, keyReady,
    input  keyOut, keyRound, keyValid, busy, done
  );

  modport slave (
    input  start, lastKey, keyIn, keyReady,
    output keyOut, keyRound, keyValid, busy, done
  );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 decryption key scheduler: expands forward to the round-10 key, then
// walks the schedule backwards, streaming round keys 10..0 on a valid/ready port.
module inv_key_schedule (
  input logic             clk,
  input logic             rstN,
  inv_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic [127:0]  key_q;
  logic          done_q;
  logic          load;
  logic          step_fwd;
  logic          hs;

  // S-box stored MSB-first so entry b lives at index ~b.
  localparam logic [255:0][7:0] sbox_lut = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox_lut[~w[23:16]], sbox_lut[~w[15:8]],
            sbox_lut[~w[7:0]],   sbox_lut[~w[31:24]]};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd1:    b = 8'h01;
      4'd2:    b = 8'h02;
      4'd3:    b = 8'h04;
      4'd4:    b = 8'h08;
      4'd5:    b = 8'h10;
      4'd6:    b = 8'h20;
      4'd7:    b = 8'h40;
      4'd8:    b = 8'h80;
      4'd9:    b = 8'h1b;
      4'd10:   b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h000000};
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_rot_word(k[31:0]) ^ rcon(i);
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ rcon(i);
    return {p0, p1, p2, p3};
  endfunction

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load) state_d = bus.lastKey ? REV : FWD;
      FWD:  if (cnt_q == 4'd9) state_d = REV;
      REV:  if (hs && cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A start landing in the done cycle is dropped: done_q blocks the load.
  always_comb begin
    load         = (state_q == IDLE) && bus.start && !done_q;
    step_fwd     = (state_q == FWD);
    hs           = (state_q == REV) && bus.keyReady;
    bus.keyValid = (state_q == REV);
    bus.busy     = (state_q != IDLE);
    bus.keyOut   = (state_q == REV) ? key_q : '0;
    bus.keyRound = (state_q == REV) ? cnt_q : '0;
    bus.done     = done_q;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      key_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= hs && (cnt_q == 4'd0);
      if (load) begin
        key_q <= bus.keyIn;
        cnt_q <= bus.lastKey ? 4'd10 : 4'd0;
      end else if (step_fwd) begin
        key_q <= fwd_step(key_q, cnt_q + 4'd1);
        cnt_q <= cnt_q + 4'd1;
      end else if (hs && cnt_q != 4'd0) begin
        key_q <= inv_step(key_q, cnt_q);
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule using FIPS-197 key-expansion vectors.
module tb_inv_key_schedule;

  logic clk  = 1'b0;
  logic rstN = 1'b1;
  always #5 clk = ~clk;

  inv_key_schedule_if bus ();

  inv_key_schedule dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  exp_t         exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [127:0] rk_a[11];
  logic [127:0] rk_c[11];
  int           ready_mode = 0;
  int           stall_cnt  = 0;
  bit           stalled_once = 1'b0;
  bit           done_pending = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compare every valid beat with the queue head, pop on handshake.
  always @(negedge clk) begin
    if (!rstN) begin
      exp_q.delete();
      done_pending = 1'b0;
    end else begin
      if (done_pending) begin
        chk("done_pulse", bus.done, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_valid", bus.keyValid, 0);
        done_pending = 1'b0;
      end else begin
        chk("done_idle", bus.done, 0);
      end
      if (bus.keyValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual_round=%0d required=none", bus.keyRound);
        end else begin
          chk("keyRound", bus.keyRound, exp_q[0].rnd);
          chk("keyOut", bus.keyOut, exp_q[0].key);
          if (bus.keyReady) begin
            if (exp_q[0].rnd == 4'd0) done_pending = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // keyReady driver: mode 0 always ready; mode 1 stalls 5 cycles at round 7, then random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        bus.keyReady = 1'b1;
      end else if (stall_cnt > 0) begin
        bus.keyReady = 1'b0;
        stall_cnt--;
      end else if (!stalled_once && bus.keyValid && bus.keyRound == 4'd7) begin
        bus.keyReady = 1'b0;
        stall_cnt    = 4;
        stalled_once = 1'b1;
      end else if (stalled_once) begin
        bus.keyReady = 1'($urandom_range(1, 0));
      end else begin
        bus.keyReady = 1'b1;
      end
    end
  end

  task automatic push_seq(input bit use_c);
    for (int r = 10; r >= 0; r--)
      exp_q.push_back('{rnd: 4'(r), key: (use_c ? rk_c[r] : rk_a[r])});
  endtask

  task automatic run(input logic [127:0] key, input bit last, input bit use_c,
                     input bit inject, input bit probe_done);
    bit got;
    push_seq(use_c);
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.lastKey = last;
    bus.keyIn   = key;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.keyIn = '0;
    chk("busy_after_start", bus.busy, 1);
    if (last) begin
      chk("valid_after_start", bus.keyValid, 1);
    end else begin
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (inject && k == 4) begin
          bus.start   = 1'b1;
          bus.lastKey = 1'b1;
          bus.keyIn   = ~key;
        end
        if (k == 5) bus.start = 1'b0;
        if (k == 9) chk("fwd_not_valid", bus.keyValid, 0);
        if (k == 10) begin
          chk("fwd_valid_at_e10", bus.keyValid, 1);
          chk("fwd_round_at_e10", bus.keyRound, 10);
        end
      end
    end
    if (inject) begin
      @(posedge clk); #1;
      bus.start   = 1'b1;
      bus.lastKey = 1'b0;
      bus.keyIn   = ~key;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_300");
    end
    if (got && probe_done) begin
      bus.start   = 1'b1;
      bus.lastKey = 1'b1;
      bus.keyIn   = key;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("start_on_done_ignored", bus.busy, 0);
    end
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_keyOut"}, bus.keyOut, 0);
    chk({tag, "_keyRound"}, bus.keyRound, 0);
    chk({tag, "_keyValid"}, bus.keyValid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rk_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rk_c[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk_c[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk_c[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk_c[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk_c[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk_c[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk_c[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk_c[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk_c[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk_c[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk_c[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    bus.start    = 1'b0;
    bus.lastKey  = 1'b0;
    bus.keyIn    = '0;
    bus.keyReady = 1'b0;

    #2 rstN = 1'b0;
    #1 chk_zero_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;

    // Forward then reverse, plus a start dropped in the done cycle.
    run(rk_a[0], 1'b0, 1'b0, 1'b0, 1'b1);
    // Direct last key.
    run(rk_a[10], 1'b1, 1'b0, 1'b0, 1'b0);
    // Backpressure.
    ready_mode   = 1;
    stall_cnt    = 0;
    stalled_once = 1'b0;
    run(rk_a[0], 1'b0, 1'b0, 1'b0, 1'b0);
    ready_mode = 0;
    // Ignored start in FWD and REV, then in REV only.
    run(rk_a[0], 1'b0, 1'b0, 1'b1, 1'b0);
    run(rk_a[10], 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset mid-operation at round 4.
    push_seq(1'b0);
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.lastKey = 1'b0;
    bus.keyIn   = rk_a[0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (bus.keyValid && bus.keyRound == 4'd4) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL round4_timeout actual=not_seen required=round4");
    end
    #2 rstN = 1'b0;
    #1 chk_zero_outputs("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    rstN = 1'b1;
    run(rk_a[0], 1'b0, 1'b0, 1'b0, 1'b0);

    // Rcon coverage with the FIPS-197 C.1 key.
    run(rk_c[0], 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

Sequential AES-128 decryption key scheduler. It takes a cipher key and runs the forward expansion one round per cycle to reach the round-10 key. It then walks the schedule backwards with the inverse expansion step, emitting round keys 10 down to 0 on a valid/ready stream. It sits between the key register and the inverse-cipher round datapath, so decryption can consume keys in the order it needs them without storing all 11 round keys.

## Interface
Parameters:
- none (AES-128 only; 10 rounds fixed)

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rstN  input  1  asynchronous, active-low reset.
- start  input  1  start request; sampled only in IDLE.
- lastKey  input  1  sampled with start. 0: keyIn is the round-0 cipher key. 1: keyIn is already the round-10 key.
- keyIn  input  128  key, byte 0 in bits [127:120]; columns are 32-bit words, col0 = [127:96].
- keyReady  input  1  consumer accepts keyOut this cycle.
- keyOut  output  128  current round key, same packing as keyIn.
- keyRound  output  4  round index of keyOut (10..0).
- keyValid  output  1  keyOut/keyRound are valid.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after round key 0 is accepted.

## Operation
- States: IDLE, FWD, REV.
- **IDLE**
  - start=1 loads keyIn into the key register.
  - lastKey=0: round counter = 0, go to FWD.
  - lastKey=1: round counter = 10, go to REV.
- **FWD**
  - Each cycle: counter ← counter+1, key ← fwd(key, counter+1).
  - When counter reaches 10, go to REV.
- **fwd(w0..w3, i)**
  - t = SubWord(RotWord(w3)) ^ Rcon(i)
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- **REV**
  - keyValid=1, keyOut = key register, keyRound = counter.
  - On handshake (keyValid & keyReady):
    - if counter==0: go to IDLE and pulse done.
    - else: key ← inv(key, counter), counter ← counter−1.
- **inv(w0..w3, i)**
  - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon(i).
- **Rcon(i)**, i=1..10: MSB byte = 01,02,04,08,10,20,40,80,1b,36; lower 24 bits = 0.
- RotWord: [a,b,c,d] → [b,c,d,a]. SubWord: the AES S-box applied per byte.
- Backpressure: with keyValid=1 and keyReady=0, keyOut and keyRound hold stable indefinitely.
- start outside IDLE is ignored; it neither restarts nor queues.
- start in the same cycle as the done pulse is ignored. done is issued from IDLE, and start is only sampled in IDLE starting the next cycle.

## Timing
- Reset (rstN=0, asynchronous):
  - state = IDLE, counter = 0, key register = 0.
  - keyOut = 0, keyRound = 0, keyValid = 0, busy = 0, done = 0.
  - Takes effect immediately, including mid-FWD or mid-REV. No partial output survives it.
- Cycle numbering: start sampled at edge E0.
  - busy=1 from E0.
  - lastKey=0: FWD occupies E1..E10; keyValid=1 from E10, with keyRound=10.
  - lastKey=1: keyValid=1 right after E0.
- Throughput: with keyReady held at 1, one key per cycle, rounds 10..0 in 11 consecutive cycles.
- Latency totals (keyReady held at 1):
  - lastKey=0: start edge to round-0 key valid = 20 cycles.
  - lastKey=1: 10 cycles.
- done: asserted for exactly one cycle, following the edge at which round 0 was accepted. In that cycle busy=0 and keyValid=0.
- keyOut and keyRound are registered. There is no combinational path from keyReady to keyOut.

## Test plan
- **Forward then reverse.** start, lastKey=0, keyIn=2b7e151628aed2a6abf7158809cf4f3c, keyReady=1 → first valid beat is keyRound=10, d014f9a8c9ee2589e13f0cc8b6630ca6. Then keyRound=9, ac7766f319fadc2128d12941575c006e, … keyRound=1, a0fafe1788542cb123a339392a6c7605, then keyRound=0 with the original key. Then a single done pulse.
- **Direct last key.** start, lastKey=1, keyIn=d014f9a8c9ee2589e13f0cc8b6630ca6 → keyValid=1 the cycle after start. Same 11-key sequence as above. done arrives 11 handshakes later.
- **Backpressure.** Hold keyReady=0 for 5 cycles at keyRound=7, then toggle it randomly → keyOut and keyRound stay stable while stalled. No round is skipped or repeated. The sequence is identical to the unstalled run.
- **Ignored start.** Pulse start with a different keyIn during FWD and again during REV → the sequence is unaffected. After done, a new start is accepted normally.
- **Reset mid-operation.** Drop rstN at keyRound=4 → all outputs go to 0 immediately. After rstN rises, a fresh start (lastKey=0) produces the full correct sequence from round 10.
- **Rcon coverage.** Run with key 000102030405060708090a0b0c0d0e0f and lastKey=0 → round-10 key 13111d7fe3944a17f307a78b4d2b30c5. The reverse walk returns 000102030405060708090a0b0c0d0e0f at keyRound=0.
